// File: rtl/lsu_mem_unit.sv
// Load/store data-memory unit for the MEM stage: byte/half/word/(double) accesses
// with a fixed LAT-cycle valid/ready handshake. Optional trap build: `define LSU_ALIGN_TRAP_EN.
module lsu_mem_unit #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 12,
    parameter int LAT    = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_signed_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [WIDTH-1:0]  req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [WIDTH-1:0]  rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int          BYTES   = WIDTH / 8;
    localparam int          OFF_W   = $clog2(BYTES);
    localparam int          IDX_W   = ADDR_W - OFF_W;
    localparam int          MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]    wdata_q, wdata_d;
    logic [WIDTH-1:0]    rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [WIDTH-1:0]    mem_q [DEPTH];

    // Access decode, driven entirely from the latched request
    logic [OFF_W-1:0]    off;
    logic [IDX_W-1:0]    idx_full;
    logic [3:0]          nbytes;
    logic [OFF_W-1:0]    size_mask;
    logic                size_ill;
    logic [OFF_W-1:0]    lane;
    logic [MEM_AW-1:0]   word_idx;
    logic                fault;

    assign off       = addr_q[OFF_W-1:0];
    assign idx_full  = addr_q[ADDR_W-1:OFF_W];
    assign nbytes    = 4'd1 << size_q;
    assign size_mask = OFF_W'(nbytes - 4'd1);
    assign size_ill  = (WIDTH == 32) && (size_q == 2'b11);

`ifdef LSU_ALIGN_TRAP_EN
    logic misalign;
    logic oob;

    assign misalign = (off & size_mask) != '0;
    assign oob      = 32'(idx_full) >= DEPTH_U;
    assign lane     = off;
    assign word_idx = MEM_AW'(idx_full);
    assign fault    = size_ill | misalign | oob;
`else
    assign lane     = off & ~size_mask;
    assign word_idx = MEM_AW'(32'(idx_full) % DEPTH_U);
    assign fault    = size_ill;
`endif

    logic [OFF_W+2:0]    shamt;
    logic [6:0]          nbits;
    logic [WIDTH-1:0]    rd_word;
    logic [WIDTH-1:0]    rd_shift;
    logic [WIDTH-1:0]    wr_shift;
    logic [WIDTH-1:0]    low_mask;
    logic [WIDTH-1:0]    top_mask;
    logic                sign_bit;
    logic [WIDTH-1:0]    load_val;
    logic [BYTES-1:0]    be;
    logic [4:0]          lane_w;
    logic                commit;
    logic                mem_we;

    assign shamt    = {lane, 3'b000};
    assign nbits    = {nbytes, 3'b000};
    assign rd_word  = mem_q[word_idx];
    assign rd_shift = rd_word >> shamt;
    assign wr_shift = wdata_q << shamt;
    assign low_mask = {WIDTH{1'b1}} >> (7'(WIDTH) - nbits);
    assign top_mask = low_mask & ~(low_mask >> 1);
    assign sign_bit = |(rd_shift & top_mask);
    assign load_val = (rd_shift & low_mask) | ((signed_q && sign_bit) ? ~low_mask : '0);
    assign lane_w   = 5'(lane);

    // Lane gi is enabled when it lies in [lane, lane+nbytes); the wrap of the
    // 5-bit difference makes lanes below the start compare as large.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_be
            assign be[gi] = (5'(gi) - lane_w) < 5'(nbytes);
        end
    endgenerate

    assign commit = (state_q == S_BUSY) && (cnt_q == 4'd0);
    assign mem_we = commit && we_q && !fault && !reset_i;

    // Array is deliberately left out of reset so it maps onto block RAM
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be[b]) begin
                    mem_q[word_idx][b*8 +: 8] <= wr_shift[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    we_d     = req_we_i;
                    size_d   = req_size_i;
                    signed_d = req_signed_i;
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    cnt_d    = 4'(LAT - 1);
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    err_d   = fault;
                    rdata_d = (fault || we_q) ? '0 : load_val;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            size_q   <= '0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_lsu_mem_unit.sv
// Randomised self-checking bench for lsu_mem_unit against a byte-array reference
// model; honours `define LSU_ALIGN_TRAP_EN in the same way as the design.
module tb_lsu_mem_unit;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 12;
    localparam int LAT    = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_signed = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [WIDTH-1:0]  req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [WIDTH-1:0]  rsp_rdata;
    logic              rsp_err;

    int checks = 0;
    int errors = 0;

    byte unsigned model_mem [DEPTH*4];

    always #5 clk = ~clk;

    lsu_mem_unit #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .LAT   (LAT)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_size_i  (req_size),
        .req_signed_i(req_signed),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err)
    );

    // Reference: little-endian byte array, access rules applied with plain arithmetic
    function automatic void model_access(input logic we, input logic [1:0] size, input logic sgn,
                                         input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                                         output logic [31:0] exp_rdata, output logic exp_err);
        int n, widx, lane, base;
        longint v;
        n = 1 << size;
        widx = int'(addr) / 4;
        lane = int'(addr) % 4;
        exp_rdata = '0;
        exp_err = 1'b0;
        if (size == 2'b11) begin
            exp_err = 1'b1;
            return;
        end
`ifdef LSU_ALIGN_TRAP_EN
        if ((lane % n) != 0 || widx >= DEPTH) begin
            exp_err = 1'b1;
            return;
        end
`else
        lane = lane - (lane % n);
        widx = widx % DEPTH;
`endif
        base = widx * 4 + lane;
        if (we) begin
            for (int i = 0; i < n; i++) model_mem[base+i] = wdata[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = v + (longint'(model_mem[base+i]) << (8*i));
            if (sgn && v >= (64'sd1 << (8*n-1))) v = v - (64'sd1 << (8*n));
            exp_rdata = v[31:0];
        end
    endfunction

    // Drives one request from IDLE (called at posedge+1) and returns observations.
    // stable=0 if req_ready/rsp outputs misbehave while waiting or under backpressure.
    task automatic do_access(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [ADDR_W-1:0] addr, input logic [31:0] wdata, input int hold,
                             output logic [31:0] rdata, output logic err, output int lat,
                             output logic stable);
        lat = -1;
        stable = 1'b1;
        rdata = 'x;
        err = 1'bx;
        req_we = we;
        req_size = size;
        req_signed = sgn;
        req_addr = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        if (rsp_valid === 1'b1) lat = 0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            if (req_ready !== 1'b0) stable = 1'b0;
            @(posedge clk);
            #1;
            if (rsp_valid === 1'b1) lat = k;
        end
        if (lat >= 0) begin
            rdata = rsp_rdata;
            err = rsp_err;
            if (req_ready !== 1'b0) stable = 1'b0;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                if (rsp_valid !== 1'b1 || rsp_rdata !== rdata || rsp_err !== err || req_ready !== 1'b0)
                    stable = 1'b0;
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) stable = 1'b0;
        end else begin
            stable = 1'b0;
        end
        $display("txn we=%0d size=%0d sgn=%0d addr=%03h wdata=%08h -> rdata=%08h err=%0d lat=%0d hold=%0d",
                 we, size, sgn, addr, wdata, rdata, err, lat, hold);
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b valid=%b rdata=%08h err=%b, want 1 0 00000000 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b valid=%b, want 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_init();
        logic [31:0] rd, er, d;
        logic e, st;
        int lat;
        for (int w = 0; w < DEPTH; w++) begin
            d = $urandom;
            model_access(1'b1, 2'b10, 1'b0, ADDR_W'(w*4), d, er, e);
            do_access(1'b1, 2'b10, 1'b0, ADDR_W'(w*4), d, 0, rd, e, lat, st);
            checks++;
            if (lat !== LAT || e !== 1'b0 || rd !== 32'h0 || st !== 1'b1) begin
                errors++;
                $display("FAIL init_store[%0d]: lat=%0d err=%b rdata=%08h stable=%b, want %0d 0 00000000 1",
                         w, lat, e, rd, st, LAT);
            end
        end
    endtask

    task automatic test_reset_busy();
        logic [31:0] rd, exp_rd;
        logic e, exp_e, st;
        int lat;
        model_access(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, exp_rd, exp_e);
        do_access(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 0, rd, e, lat, st);
        checks++;
        if (rd !== exp_rd || e !== exp_e || lat !== LAT) begin
            errors++;
            $display("FAIL pre_reset_load: rdata=%08h err=%b lat=%0d, want %08h %b %0d", rd, e, lat, exp_rd, exp_e, LAT);
        end
        req_we = 1'b1;
        req_size = 2'b10;
        req_signed = 1'b0;
        req_addr = 12'h010;
        req_wdata = ~exp_rd;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_busy: ready=%b valid=%b rdata=%08h err=%b, want 1 0 00000000 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        do_access(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 0, rd, e, lat, st);
        checks++;
        if (rd !== exp_rd || e !== 1'b0 || lat !== LAT || st !== 1'b1) begin
            errors++;
            $display("FAIL store_discarded: rdata=%08h err=%b lat=%0d, want %08h 0 %0d", rd, e, lat, exp_rd, LAT);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd, er;
        logic e, st;
        int lat;
        model_access(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, er, e);
        do_access(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 0, rd, e, lat, st);
        checks++;
        if (lat !== LAT || e !== 1'b0 || rd !== 32'h0 || st !== 1'b1) begin
            errors++;
            $display("FAIL sw_010: lat=%0d err=%b rdata=%08h, want %0d 0 00000000", lat, e, rd, LAT);
        end
        do_access(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 0, rd, e, lat, st);
        checks++;
        if (lat !== LAT || e !== 1'b0 || rd !== 32'hDEADBEEF || st !== 1'b1) begin
            errors++;
            $display("FAIL lw_010: lat=%0d err=%b rdata=%08h, want %0d 0 deadbeef", lat, e, rd, LAT);
        end
    endtask

    task automatic test_extend();
        logic [1:0]  sz  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        sg  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [11:0] ad  [4] = '{12'h013, 12'h013, 12'h012, 12'h010};
        logic [31:0] ex  [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
        logic [31:0] rd;
        logic e, st;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_access(1'b0, sz[i], sg[i], ad[i], 32'h0, 0, rd, e, lat, st);
            checks++;
            if (rd !== ex[i] || e !== 1'b0 || lat !== LAT) begin
                errors++;
                $display("FAIL extend[%0d]: rdata=%08h err=%b lat=%0d, want %08h 0 %0d", i, rd, e, lat, ex[i], LAT);
            end
        end
    endtask

    task automatic test_partial_store();
        logic [31:0] rd, er;
        logic e, st;
        int lat;
        model_access(1'b1, 2'b00, 1'b0, 12'h011, 32'hAAAAAA55, er, e);
        do_access(1'b1, 2'b00, 1'b0, 12'h011, 32'hAAAAAA55, 0, rd, e, lat, st);
        do_access(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 0, rd, e, lat, st);
        checks++;
        if (rd !== 32'hDEAD55EF || e !== 1'b0) begin
            errors++;
            $display("FAIL sb_011: rdata=%08h err=%b, want dead55ef 0", rd, e);
        end
        model_access(1'b1, 2'b01, 1'b0, 12'h012, 32'hFFFF1234, er, e);
        do_access(1'b1, 2'b01, 1'b0, 12'h012, 32'hFFFF1234, 0, rd, e, lat, st);
        do_access(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 0, rd, e, lat, st);
        checks++;
        if (rd !== 32'h123455EF || e !== 1'b0) begin
            errors++;
            $display("FAIL sh_012: rdata=%08h err=%b, want 123455ef 0", rd, e);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic e, st;
        int lat;
        do_access(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 5, rd, e, lat, st);
        checks++;
        if (st !== 1'b1 || rd !== 32'h123455EF || e !== 1'b0 || lat !== LAT) begin
            errors++;
            $display("FAIL backpressure: stable=%b rdata=%08h err=%b lat=%0d, want 1 123455ef 0 %0d",
                     st, rd, e, lat, LAT);
        end
    endtask

    task automatic test_align();
        logic [31:0] rd, exp_rd;
        logic e, exp_e, st;
        int lat;
        do_access(1'b0, 2'b10, 1'b0, 12'h012, 32'h0, 0, rd, e, lat, st);
        checks++;
`ifdef LSU_ALIGN_TRAP_EN
        if (rd !== 32'h0 || e !== 1'b1 || lat !== LAT) begin
            errors++;
            $display("FAIL lw_misaligned: rdata=%08h err=%b lat=%0d, want 00000000 1 %0d", rd, e, lat, LAT);
        end
`else
        if (rd !== 32'h123455EF || e !== 1'b0 || lat !== LAT) begin
            errors++;
            $display("FAIL lw_misaligned: rdata=%08h err=%b lat=%0d, want 123455ef 0 %0d", rd, e, lat, LAT);
        end
`endif
        model_access(1'b1, 2'b10, 1'b0, ADDR_W'(DEPTH*4), 32'hCAFEF00D, exp_rd, exp_e);
        do_access(1'b1, 2'b10, 1'b0, ADDR_W'(DEPTH*4), 32'hCAFEF00D, 0, rd, e, lat, st);
        checks++;
        if (e !== exp_e || rd !== 32'h0) begin
            errors++;
            $display("FAIL sw_out_of_range: err=%b rdata=%08h, want %b 00000000", e, rd, exp_e);
        end
        model_access(1'b0, 2'b10, 1'b0, 12'h000, 32'h0, exp_rd, exp_e);
        do_access(1'b0, 2'b10, 1'b0, 12'h000, 32'h0, 0, rd, e, lat, st);
        checks++;
        if (rd !== exp_rd || e !== 1'b0) begin
            errors++;
            $display("FAIL word0_after_oob: rdata=%08h err=%b, want %08h 0", rd, e, exp_rd);
        end
        model_access(1'b1, 2'b11, 1'b0, 12'h020, 32'h13579BDF, exp_rd, exp_e);
        do_access(1'b1, 2'b11, 1'b0, 12'h020, 32'h13579BDF, 0, rd, e, lat, st);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0 || lat !== LAT) begin
            errors++;
            $display("FAIL illegal_size: err=%b rdata=%08h lat=%0d, want 1 00000000 %0d", e, rd, lat, LAT);
        end
        model_access(1'b0, 2'b10, 1'b0, 12'h020, 32'h0, exp_rd, exp_e);
        do_access(1'b0, 2'b10, 1'b0, 12'h020, 32'h0, 0, rd, e, lat, st);
        checks++;
        if (rd !== exp_rd || e !== 1'b0) begin
            errors++;
            $display("FAIL illegal_size_nowrite: rdata=%08h err=%b, want %08h 0", rd, e, exp_rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp_rd, d;
        logic e, exp_e, st, we, sgn;
        logic [1:0] sz;
        logic [ADDR_W-1:0] ad;
        int lat, hold;
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sgn = 1'($urandom_range(0, 1));
            ad = ADDR_W'($urandom);
            d = $urandom;
            hold = $urandom_range(0, 3);
            model_access(we, sz, sgn, ad, d, exp_rd, exp_e);
            do_access(we, sz, sgn, ad, d, hold, rd, e, lat, st);
            checks++;
            if (rd !== exp_rd || e !== exp_e || lat !== LAT || st !== 1'b1) begin
                errors++;
                $display("FAIL random[%0d]: rdata=%08h err=%b lat=%0d stable=%b, want %08h %b %0d 1",
                         i, rd, e, lat, st, exp_rd, exp_e, LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_reset_busy();
        test_word();
        test_extend();
        test_partial_store();
        test_backpressure();
        test_align();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_unit.md
Name: lsu_mem_unit

Overview:
- Parametrised load/store data-memory unit for the processor's MEM stage.
- Successor to the fixed word-only data memory.
- Adds byte, halfword and word (and doubleword at WIDTH=64) accesses, signed/unsigned loads and a configurable access latency.
- Uses a valid/ready request/response handshake so the pipeline can stall on memory.

Parameters:
- WIDTH, 32, data word width in bits; legal values 32 or 64.
- DEPTH, 256, number of WIDTH-bit words in the internal array.
- ADDR_W, 12, byte-address width; must satisfy 2^ADDR_W >= DEPTH*WIDTH/8.
- LAT, 1, cycles from request accept to rsp_valid; legal 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word(32), 11 double (WIDTH=64 only).
- req_signed  in  1  sign-extend load result.
- req_addr  in  ADDR_W  byte address, little-endian.
- req_wdata  in  WIDTH  store data, right-justified.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  WIDTH  load result, extended to WIDTH; 0 for stores.
- rsp_err  out  1  access faulted (see Optional Feature).

Behaviour:
- Reset (async, any state): FSM to IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. Memory array is not cleared. A store not yet committed is discarded.
- FSM states:
  - IDLE: req_ready=1. On req_valid at a clk edge, latch we/size/signed/addr/wdata and go to BUSY with cnt=LAT-1.
  - BUSY: req_ready=0. Decrement cnt. At the edge where cnt==0, commit the access and go to RESP with rsp_valid=1.
  - RESP: req_ready=0. rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready=1. On that edge go to IDLE with rsp_valid=0.
- Net timing: rsp_valid rises exactly LAT edges after the accept edge. Minimum turnaround is LAT+2 cycles per access. There is no same-cycle accept while in RESP.
- Indexing: word index = req_addr >> log2(WIDTH/8); lane = req_addr[log2(WIDTH/8)-1:0].
- Store commit: write only the addressed byte lanes, taken from the low bytes of wdata. Other lanes are unchanged.
- Load: read the word, select the addressed lanes, then zero-extend or sign-extend (req_signed) to WIDTH.
- Read and write for one request occur at the same commit edge. A load following a store always sees the stored data.
- req_size=11 with WIDTH=32 is treated as illegal size: rsp_err=1 and no write.
- Word index >= DEPTH is handled per the macro.
- req_valid while not ready is ignored; inputs are not latched.

Optional Feature:
- Macro: LSU_ALIGN_TRAP_EN
- Defined:
  - Misaligned access (lane not a multiple of the access size) or word index >= DEPTH gives rsp_err=1 and rsp_rdata=0.
  - A faulting store does not write.
  - Timing is unchanged.
- Undefined:
  - The lane offset is forced aligned (low bits cleared to the access size).
  - The word index wraps modulo DEPTH.
  - rsp_err=1 only for an illegal req_size.

Test Plan:
1. Reset, LAT=1 -> req_ready=1, rsp_valid=0, rsp_rdata=0x00000000, rsp_err=0. Assert reset during BUSY of a store (LAT=3) to 0x010 -> later LW 0x010 returns the pre-existing value.
2. SW 0xDEADBEEF @0x010, then LW @0x010 -> rsp_valid exactly LAT edges after accept, rdata=0xDEADBEEF, err=0.
3. After test 2, sign/zero extension:
   - LB signed @0x013 -> 0xFFFFFFDE
   - LBU @0x013 -> 0x000000DE
   - LH signed @0x012 -> 0xFFFFDEAD
   - LHU @0x010 -> 0x0000BEEF
4. SB 0x55 @0x011 then LW @0x010 -> 0xDEAD55EF. SH 0x1234 @0x012 then LW -> 0x123455EF.
5. Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid=1, rdata and err stable, req_ready=0 throughout. IDLE is re-entered on the edge where rsp_ready=1.
6. LW @0x012:
   - With LSU_ALIGN_TRAP_EN: err=1, rdata=0.
   - Without: returns the word @0x010, err=0.
   - SW @DEPTH*4 with the macro: err=1 and word 0 is unchanged.
